// File: rtl/cnn16_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cnn16_ram_arbiter_if
//  Description : One requester's view of the shared CNN working RAM.
//                The bundle carries the request handshake (valid/ready), the
//                access fields (we/addr/wdata) and the read-response path
//                (rsp_valid/rsp_rdata, no backpressure).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cnn16_ram_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    // Requester side: issues accesses, receives grants and read data
    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    // Arbiter side: receives accesses, returns grants and read data
    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cnn16_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cnn16_ram_arbiter
//  Description : Two-requester round-robin arbiter in front of the single-port
//                16-bit CNN working RAM (1-cycle registered read).
//                req0 = loader/writeback, req1 = conv engine.
//                At most one access per cycle; read data is routed back to the
//                issuing port one cycle after acceptance.
//                Optional feature macro: CNN16_ARB_STATS_EN adds saturating
//                grant/conflict statistics counters and a stats_clr input.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn16_ram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cnn16_ram_arbiter_if.slave    req0,
    cnn16_ram_arbiter_if.slave    req1,
    output logic                  ram_mem_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef CNN16_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [CNT_WIDTH-1:0]  grant0_cnt,
    output logic [CNT_WIDTH-1:0]  grant1_cnt,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
`endif
);

    // last_q holds the port granted most recently; it resets to 1 so that
    // port 0 wins the first conflict after reset.
    logic last_q;
    // pend_q: a read was accepted in the previous cycle; pid_q: its port.
    logic pend_q;
    logic pid_q;

    logic grant0;
    logic grant1;
    logic rd_accept;
    logic rsp0_sel;
    logic rsp1_sel;

    // Round-robin grant; reset suppresses all grants so the RAM sees idle reads
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0.valid && req1.valid) begin
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = req0.valid;
                grant1 = req1.valid;
            end
        end
    end

    assign req0.ready = grant0;
    assign req1.ready = grant1;

    // A grant always coincides with valid, so a grant is a handshake.
    assign rd_accept = (grant0 && !req0.we) || (grant1 && !req1.we);

    // RAM drive follows the granted request; no grant means a dummy read of 0
    always_comb begin
        ram_mem_write = 1'b0;
        ram_address   = '0;
        ram_data_in   = '0;
        if (grant0) begin
            ram_mem_write = req0.we;
            ram_address   = req0.addr;
            ram_data_in   = req0.wdata;
        end else if (grant1) begin
            ram_mem_write = req1.we;
            ram_address   = req1.addr;
            ram_data_in   = req1.wdata;
        end
    end

    // Arbitration history and read-response tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
            pend_q <= 1'b0;
            pid_q  <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                last_q <= grant1;
            end
            pend_q <= rd_accept;
            if (rd_accept) begin
                pid_q <= grant1;
            end
        end
    end

    // A read outstanding when reset arrives is dropped: rst masks the response.
    assign rsp0_sel = pend_q && !pid_q && !rst;
    assign rsp1_sel = pend_q &&  pid_q && !rst;

    assign req0.rsp_valid = rsp0_sel;
    assign req1.rsp_valid = rsp1_sel;
    assign req0.rsp_rdata = rsp0_sel ? ram_data_out : '0;
    assign req1.rsp_rdata = rsp1_sel ? ram_data_out : '0;

`ifdef CNN16_ARB_STATS_EN
    // Saturating statistics counters; clear has priority over increment
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            grant0_cnt   <= '0;
            grant1_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant0 && (grant0_cnt != '1)) begin
                grant0_cnt <= grant0_cnt + 1'b1;
            end
            if (grant1 && (grant1_cnt != '1)) begin
                grant1_cnt <= grant1_cnt + 1'b1;
            end
            if (req0.valid && req1.valid && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end
`endif

    // A requester must hold its request stable until it is granted.
    a_req0_hold: assert property (@(posedge clk) disable iff (rst)
        (req0.valid && !req0.ready) |=>
        (req0.valid && $stable(req0.we) && $stable(req0.addr) && $stable(req0.wdata)));

    a_req1_hold: assert property (@(posedge clk) disable iff (rst)
        (req1.valid && !req1.ready) |=>
        (req1.valid && $stable(req1.we) && $stable(req1.addr) && $stable(req1.wdata)));

    // Counter width must be usable whenever statistics are built in.
    a_cnt_width: assert property (@(posedge clk) CNT_WIDTH > 0);

endmodule
`default_nettype wire
